// File: rtl/reg8_rr_write_arb.sv
// Round-robin write arbiter owning one shared register: IDLE -> GRANT -> ACK per write.
// Outputs are all registered; async active-low clear aborts any write in flight.
module reg8_rr_write_arb #(
    parameter int              N_REQ   = 4,
    parameter int              DW      = 8,
    parameter logic [DW-1:0]   RST_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*DW-1:0]       data_i,
    output logic [N_REQ-1:0]          grant_o,
    output logic [N_REQ-1:0]          ack_o,
    output logic [DW-1:0]             q_o,
    output logic [$clog2(N_REQ)-1:0]  owner_o,
    output logic                      upd_o,
    output logic                      busy_o
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

    state_t          state_reg;
    logic [IW-1:0]   ptr_reg;
    logic [IW-1:0]   win_reg;

    logic [DW-1:0]   data_arr [N_REQ];
    logic [N_REQ-1:0] pick_onehot;
    logic [N_REQ-1:0] win_onehot;
    logic [IW-1:0]   pick_idx;
    logic [IW:0]     cand;
    logic            found;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign data_arr[gi]    = data_i[gi*DW +: DW];
            assign pick_onehot[gi] = (pick_idx == IW'(gi));
            assign win_onehot[gi]  = (win_reg == IW'(gi));
        end
    endgenerate

    // First set request scanning ptr, ptr+1, ... with wrap at N_REQ (N_REQ need not be a power of 2).
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr_reg} + (IW+1)'(i);
            if (cand >= (IW+1)'(N_REQ)) begin
                cand = cand - (IW+1)'(N_REQ);
            end
            if (!found && req_i[cand[IW-1:0]]) begin
                found    = 1'b1;
                pick_idx = cand[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            win_reg   <= '0;
            q_o       <= RST_VAL;
            grant_o   <= '0;
            ack_o     <= '0;
            upd_o     <= 1'b0;
            owner_o   <= '0;
            busy_o    <= 1'b0;
        end else begin
            ack_o <= '0;
            upd_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (found) begin
                        win_reg   <= pick_idx;
                        grant_o   <= pick_onehot;
                        busy_o    <= 1'b1;
                        state_reg <= GRANT;
                    end
                end
                GRANT: begin
                    grant_o <= '0;
                    // A withdrawn request leaves q_o, owner and pointer untouched.
                    if (req_i[win_reg]) begin
                        q_o       <= data_arr[win_reg];
                        ack_o     <= win_onehot;
                        upd_o     <= 1'b1;
                        owner_o   <= win_reg;
                        state_reg <= ACK;
                    end else begin
                        busy_o    <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                ACK: begin
                    ptr_reg   <= (win_reg == IW'(N_REQ-1)) ? '0 : win_reg + 1'b1;
                    busy_o    <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    grant_o   <= '0;
                    busy_o    <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
